dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// One master port of the data-memory arbiter: a level request with
// write/lock qualifiers, a one-cycle grant and a registered read return.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory: round-robin between the
// datapath (m0) and debug/loader (m1) ports, with lock for back-to-back access.
module dmem_arbiter (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT0  = 3'd1,
    GNT1  = 3'd2,
    HOLD0 = 3'd3,
    HOLD1 = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;  // master that wins a tie in IDLE (0 = m0)
  logic   rd0, rd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) state_nxt = ptr ? GNT1 : GNT0;
        else if (m0.req)      state_nxt = GNT0;
        else if (m1.req)      state_nxt = GNT1;
      end
      GNT0: begin
        if (m0.lock) state_nxt = HOLD0;
        else begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      GNT1: begin
        if (m1.lock) state_nxt = HOLD1;
        else begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      // The holder owns the memory; the other master's request is not looked at.
      HOLD0: begin
        if (m0.req) state_nxt = GNT0;
        else if (!m0.lock) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      HOLD1: begin
        if (m1.req) state_nxt = GNT1;
        else if (!m1.lock) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory drive is decoded from state alone, so an async reset drops it at once.
  always_comb begin
    m0.gnt    = (state == GNT0);
    m1.gnt    = (state == GNT1);
    busy      = (state != IDLE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      GNT0: begin
        mem_we    = m0.we;
        mem_addr  = m0.addr;
        mem_wdata = m0.wdata;
      end
      GNT1: begin
        mem_we    = m1.we;
        mem_addr  = m1.addr;
        mem_wdata = m1.wdata;
      end
      default: ;
    endcase
  end

  assign rd0 = (state == GNT0) && !m0.we;
  assign rd1 = (state == GNT1) && !m1.we;

  // Read data is captured at the edge closing the grant; rdata holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
    end else begin
      m0.rvalid <= rd0;
      m1.rvalid <= rd1;
      if (rd0) m0.rdata <= mem_rdata;
      if (rd1) m1.rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Master-side drive and observation, indexed by master number.
  logic        req_d [2];
  logic        we_d  [2];
  logic        lock_d[2];
  logic [31:0] addr_d[2];
  logic [31:0] wdata_d[2];
  logic        gnt_o [2];
  logic        rvalid_o[2];
  logic [31:0] rdata_o[2];

  assign m0_if.req   = req_d[0];
  assign m0_if.we    = we_d[0];
  assign m0_if.lock  = lock_d[0];
  assign m0_if.addr  = addr_d[0];
  assign m0_if.wdata = wdata_d[0];
  assign m1_if.req   = req_d[1];
  assign m1_if.we    = we_d[1];
  assign m1_if.lock  = lock_d[1];
  assign m1_if.addr  = addr_d[1];
  assign m1_if.wdata = wdata_d[1];
  assign gnt_o[0]    = m0_if.gnt;
  assign gnt_o[1]    = m1_if.gnt;
  assign rvalid_o[0] = m0_if.rvalid;
  assign rvalid_o[1] = m1_if.rvalid;
  assign rdata_o[0]  = m0_if.rdata;
  assign rdata_o[1]  = m1_if.rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEAD_BEEF : (32'h5000_0000 + i * 32'h0001_0203);
  endfunction

  // Memory seen by the DUT: combinational read, written mid-cycle while mem_we is high.
  logic [31:0] dmem [64];
  assign mem_rdata = dmem[mem_addr[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mem_we) dmem[mem_addr[7:2]] = mem_wdata;
    end
  end

  // ---------------- behavioural model ----------------
  // g_now: master being served this cycle; h_now: master owning the memory by lock.
  int          g_now, h_now, ptr_m;
  logic [31:0] ref_mem [64];
  logic        e_rvalid[2];
  logic [31:0] e_rdata [2];
  logic        s_req[2], s_we[2], s_lock[2];
  logic [31:0] s_addr[2], s_wdata[2];
  logic        gnt_seen[2];

  task automatic model_reset();
    g_now = -1;
    h_now = -1;
    ptr_m = 0;
    for (int m = 0; m < 2; m++) begin
      e_rvalid[m] = 1'b0;
      e_rdata[m]  = '0;
    end
  endtask

  task automatic model_step();
    int g_nx, h_nx;
    g_nx = -1;
    h_nx = h_now;
    for (int m = 0; m < 2; m++) e_rvalid[m] = 1'b0;
    if (g_now >= 0) begin
      if (s_we[g_now]) ref_mem[s_addr[g_now][7:2]] = s_wdata[g_now];
      else begin
        e_rvalid[g_now] = 1'b1;
        e_rdata[g_now]  = ref_mem[s_addr[g_now][7:2]];
      end
      if (s_lock[g_now]) h_nx = g_now;
      else begin
        h_nx  = -1;
        ptr_m = 1 - g_now;
      end
    end else if (h_now >= 0) begin
      if (s_req[h_now]) begin
        g_nx = h_now;
        h_nx = -1;
      end else if (!s_lock[h_now]) begin
        h_nx  = -1;
        ptr_m = 1 - h_now;
      end
    end else begin
      if (s_req[0] && s_req[1]) g_nx = ptr_m;
      else if (s_req[0])        g_nx = 0;
      else if (s_req[1])        g_nx = 1;
    end
    g_now = g_nx;
    h_now = h_nx;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model, then snapshot of this cycle's inputs.
  always @(negedge clk) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("m%0d_gnt", m), gnt_o[m], g_now == m);
        check($sformatf("m%0d_rvalid", m), rvalid_o[m], e_rvalid[m]);
        check($sformatf("m%0d_rdata", m), rdata_o[m], e_rdata[m]);
      end
      if (g_now >= 0) begin
        check("mem_we", mem_we, we_d[g_now]);
        check("mem_addr", mem_addr, addr_d[g_now]);
        check("mem_wdata", mem_wdata, wdata_d[g_now]);
      end else begin
        check("mem_we", mem_we, 0);
        check("mem_addr", mem_addr, 0);
        check("mem_wdata", mem_wdata, 0);
      end
      check("busy", busy, (g_now >= 0) || (h_now >= 0));
    end
    for (int m = 0; m < 2; m++) begin
      s_req[m]    = req_d[m];
      s_we[m]     = we_d[m];
      s_lock[m]   = lock_d[m];
      s_addr[m]   = addr_d[m];
      s_wdata[m]  = wdata_d[m];
      gnt_seen[m] = gnt_o[m];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input int m, input logic rq, input logic w, input logic lk,
                       input logic [31:0] a, input logic [31:0] d);
    req_d[m]   = rq;
    we_d[m]    = w;
    lock_d[m]  = lk;
    addr_d[m]  = a;
    wdata_d[m] = d;
  endtask

  task automatic do_reset();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns the absolute cycle of the next grant to master m, or -1 on timeout.
  task automatic wait_gnt(input int m, input int limit, output int at);
    at = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (gnt_o[m]) begin
        at = cyc;
        break;
      end
    end
  endtask

  logic pend[2];
  task automatic rand_step(input int m);
    if (pend[m] && gnt_seen[m]) pend[m] = 1'b0;
    else if (pend[m] && g_now != m && $urandom_range(0, 24) == 0) pend[m] = 1'b0;
    if (!pend[m] && $urandom_range(0, 2) == 0) begin
      pend[m]    = 1'b1;
      we_d[m]    = ($urandom_range(0, 1) == 1);
      addr_d[m]  = $urandom;
      wdata_d[m] = $urandom;
    end
    req_d[m] = pend[m];
    if ($urandom_range(0, 5) == 0) lock_d[m] = ~lock_d[m];
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0, at, t_drop, who;
    int exp22[8];
    exp22 = '{-1, 0, -1, 1, -1, 0, -1, 1};
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);

    // Outputs while reset is held.
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_gnt", {gnt_o[1], gnt_o[0]}, 0);
    check("rst_rvalid", {rvalid_o[1], rvalid_o[0]}, 0);
    check("rst_rdata0", rdata_o[0], 0);

    // Single read of word 2.
    do_reset();
    t0 = cyc;
    set_m(0, 1, 0, 0, 32'h8, 0);
    wait_gnt(0, 6, at);
    check("r020_gnt_cycle", at - t0, 1);
    next_cycle();
    set_m(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r020_rvalid", rvalid_o[0], 1);
    check("r020_rdata", rdata_o[0], 32'hDEAD_BEEF);

    // Simultaneous writes from a fresh reset: m0 first, m1 two cycles later.
    do_reset();
    t0 = cyc;
    set_m(0, 1, 1, 0, 32'h0, 32'h11);
    set_m(1, 1, 1, 0, 32'h4, 32'h22);
    wait_gnt(0, 6, at);
    check("r021_m0_gnt_cycle", at - t0, 1);
    next_cycle();
    set_m(0, 0, 0, 0, 0, 0);
    wait_gnt(1, 6, at);
    check("r021_m1_gnt_cycle", at - t0, 3);
    next_cycle();
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r021_word0", dmem[0], 32'h11);
    check("r021_word1", dmem[1], 32'h22);

    // Both masters requesting continuously: grants alternate.
    do_reset();
    set_m(0, 1, 0, 0, 32'h30, 0);
    set_m(1, 1, 0, 0, 32'h34, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      who = gnt_o[0] ? 0 : (gnt_o[1] ? 1 : -1);
      check($sformatf("r022_grant_c%0d", c), who, exp22[c]);
    end
    next_cycle();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);

    // Locked m1 does three reads while m0 waits.
    do_reset();
    t0 = cyc;
    set_m(1, 1, 0, 1, 32'h40, 0);
    next_cycle();
    set_m(0, 1, 0, 0, 32'h80, 0);
    for (int k = 0; k < 3; k++) begin
      wait_gnt(1, 6, at);
      check($sformatf("r023_m1_gnt%0d_cycle", k), at - t0, 1 + 2 * k);
      next_cycle();
      if (k < 2) addr_d[1] = 32'h44 + 32'(4 * k);
      else       set_m(1, 0, 0, 0, 0, 0);
    end
    t_drop = cyc;
    wait_gnt(0, 8, at);
    check("r023_m0_after_unlock", at - t_drop, 2);
    next_cycle();
    set_m(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset asserted in the middle of an m0 write grant.
    next_cycle();
    set_m(0, 1, 1, 0, 32'h20, 32'hCAFE_F00D);
    next_cycle();
    check("r024_we_before", mem_we, 1);
    reset = 1'b0;
    #1;
    check("r024_mem_we", mem_we, 0);
    check("r024_mem_addr", mem_addr, 0);
    check("r024_mem_wdata", mem_wdata, 0);
    check("r024_busy", busy, 0);
    check("r024_gnt", {gnt_o[1], gnt_o[0]}, 0);
    check("r024_rvalid", {rvalid_o[1], rvalid_o[0]}, 0);
    check("r024_rdata0", rdata_o[0], 0);
    check("r024_rdata1", rdata_o[1], 0);
    set_m(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("r024_word8_kept", dmem[8], init_word(8));
    check("r024_no_rvalid", rvalid_o[0], 0);

    // Write then read back through m1.
    do_reset();
    set_m(1, 1, 1, 0, 32'h10, 32'h5A);
    wait_gnt(1, 6, at);
    next_cycle();
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r025_write_no_rvalid", rvalid_o[1], 0);
    next_cycle();
    set_m(1, 1, 0, 0, 32'h10, 0);
    wait_gnt(1, 6, at);
    next_cycle();
    set_m(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r025_rvalid", rvalid_o[1], 1);
    check("r025_rdata", rdata_o[1], 32'h5A);
    @(negedge clk);
    check("r025_rvalid_drop", rvalid_o[1], 0);
    check("r025_rdata_hold", rdata_o[1], 32'h5A);

    // Randomized traffic, checked every cycle by the compare process.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rand_step(0);
      rand_step(1);
    end
    next_cycle();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 64; i++) check($sformatf("mem_word%0d", i), dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
